// File: rtl/intbus_arb_pkg.sv
// Shared FSM encoding, defaults and helpers for the internal-bus master arbiter.
package intbus_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/intbus_master_arb_rr.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0] rot;
  logic            found;
  int unsigned     pos;

  // Rotate so the search always scans from bit 0, then map back to a real index.
  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 32'(ptr) + i;
      end
    end
    if (pos >= NREQ) pos = pos - NREQ;
    idx   = IW'(pos);
    grant = found ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/intbus_master_arb.sv
// Shares the internal register bus between NREQ masters, one transaction at a time.
module intbus_master_arb
  import intbus_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic [DW-1:0]     bus_rdata,
  input  logic              bus_rvalid
);
  localparam int unsigned   IW       = $clog2(NREQ);
  localparam int unsigned   CW       = $clog2(TIMEOUT);
  // Last WAIT_RD count: gives rsp_valid exactly TIMEOUT+1 cycles after the grant.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] owner;
  logic [CW-1:0]   cnt;
  logic            lat_wr;
  req_t            sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) sel = '{wr: req_wr[i], addr: req_addr[i*AW +: AW], wdata: req_wdata[i*DW +: DW]};
    end
  end

  assign req_ready = (resetn && state == IDLE) ? grant : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= grant;
            ptr       <= IW'(wrap_inc(32'(gidx), NREQ));
            lat_wr    <= sel.wr;
            bus_addr  <= sel.addr;
            bus_wdata <= sel.wdata;
            bus_wr    <= sel.wr;
            bus_rd    <= !sel.wr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_wr) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= owner;
            state     <= RESP;
          end else if (bus_rvalid) begin
            rsp_rdata <= bus_rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= owner;
            state     <= RESP;
          end else begin
            cnt   <= '0;
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid) begin
            rsp_rdata <= bus_rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= owner;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_rdata <= DW'(ERR_DATA);
            rsp_err   <= 1'b1;
            rsp_valid <= owner;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intbus_master_arb.sv
// Directed bench for intbus_master_arb: per-cycle vector table plus timeout/reset sequences.
module tb_intbus_master_arb;
  localparam int unsigned TO = 8;

  logic        clk, resetn;
  logic [1:0]  req_valid, req_wr, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        rsp_err, bus_wr, bus_rd, bus_rvalid;

  intbus_master_arb #(.NREQ(2), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rv, wr, a0, a1, d0, d1, rvl, rd;
    logic [31:0] rdy, rsp, rdata, err, addr, wdata, bwr, brd;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   passed = 0;
  int   lat;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic add(input logic [31:0] rv, wr, a0, a1, d0, d1, rvl, rd,
                     input logic [31:0] rdy, rsp, rdata, err, addr, wdata, bwr, brd);
    tbl.push_back('{rv, wr, a0, a1, d0, d1, rvl, rd, rdy, rsp, rdata, err, addr, wdata, bwr, brd});
  endtask

  task automatic grant(input logic [1:0] v, input logic [31:0] addr,
                       input logic [1:0] exp_rdy, input string nm);
    @(posedge clk); #1;
    req_valid = v; req_wr = 2'b00; req_addr = {addr, addr}; req_wdata = '0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk(nm, 32'(req_ready), 32'(exp_rdy));
  endtask

  // Drops the request, pulses rvalid in cycle rv_at after the grant, returns rsp latency.
  task automatic run_read(input int rv_at, input logic [31:0] data, output int l);
    l = 0;
    for (int n = 1; n <= 40 && l == 0; n++) begin
      @(posedge clk); #1;
      req_valid  = '0;
      bus_rvalid = (n == rv_at);
      bus_rdata  = data;
      @(negedge clk);
      if (rsp_valid != '0) l = n;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    bus_rdata = '0; bus_rvalid = 1'b0;

    //    rv wr a0      a1      d0       d1      rvl rd         rdy rsp rdata    err addr    wdata    bwr brd
    add(1, 1, 'h10,   0,      'hA5A5,  0,      0, 0,         1,  0,  0,       0,  0,      0,       0,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  0,  0,       0,  'h10,   'hA5A5,  1,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  1,  0,       0,  'h10,   'hA5A5,  0,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  0,  0,       0,  'h10,   'hA5A5,  0,  0);
    add(2, 0, 0,      'h20,   0,       0,      0, 0,         2,  0,  0,       0,  'h10,   'hA5A5,  0,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  0,  0,       0,  'h20,   0,       0,  1);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  0,  0,       0,  'h20,   0,       0,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  0,  0,       0,  'h20,   0,       0,  0);
    add(0, 0, 0,      0,      0,       0,      1, 'h1234,    0,  0,  0,       0,  'h20,   0,       0,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  2,  'h1234,  0,  'h20,   0,       0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         1,  0,  'h1234,  0,  'h20,   0,       0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  0,  'h1234,  0,  'h100,  'h111,   1,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  1,  0,       0,  'h100,  'h111,   0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         2,  0,  0,       0,  'h100,  'h111,   0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  0,  0,       0,  'h200,  'h222,   1,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  2,  0,       0,  'h200,  'h222,   0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         1,  0,  0,       0,  'h200,  'h222,   0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  0,  0,       0,  'h100,  'h111,   1,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  1,  0,       0,  'h100,  'h111,   0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         2,  0,  0,       0,  'h100,  'h111,   0,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  0,  0,       0,  'h200,  'h222,   1,  0);
    add(3, 3, 'h100,  'h200,  'h111,   'h222,  0, 0,         0,  2,  0,       0,  'h200,  'h222,   0,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  0,  0,       0,  'h200,  'h222,   0,  0);
    add(1, 0, 'h30,   0,      0,       0,      0, 0,         1,  0,  0,       0,  'h200,  'h222,   0,  0);
    add(0, 0, 0,      0,      0,       0,      1, 'h5678,    0,  0,  0,       0,  'h30,   0,       0,  1);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  1,  'h5678,  0,  'h30,   0,       0,  0);
    add(0, 0, 0,      0,      0,       0,      1, 'h9999,    0,  0,  'h5678,  0,  'h30,   0,       0,  0);
    add(0, 0, 0,      0,      0,       0,      0, 0,         0,  0,  'h5678,  0,  'h30,   0,       0,  0);

    // Reset state, with both requesters asking so req_ready must stay quiet.
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_strobes", 32'({bus_wr, bus_rd}), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      resetn     = 1'b1;
      req_valid  = tbl[i].rv[1:0];
      req_wr     = tbl[i].wr[1:0];
      req_addr   = {tbl[i].a1, tbl[i].a0};
      req_wdata  = {tbl[i].d1, tbl[i].d0};
      bus_rvalid = tbl[i].rvl[0];
      bus_rdata  = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(req_ready), tbl[i].rdy);
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), tbl[i].rsp);
      chk($sformatf("row%0d rdata", i), rsp_rdata, tbl[i].rdata);
      chk($sformatf("row%0d err", i), 32'(rsp_err), tbl[i].err);
      chk($sformatf("row%0d bus_addr", i), bus_addr, tbl[i].addr);
      chk($sformatf("row%0d bus_wdata", i), bus_wdata, tbl[i].wdata);
      chk($sformatf("row%0d bus_wr", i), 32'(bus_wr), tbl[i].bwr);
      chk($sformatf("row%0d bus_rd", i), 32'(bus_rd), tbl[i].brd);
    end

    // Read timeout on requester 1, then a stray rvalid that must be ignored.
    grant(2'b10, 'h40, 2'b10, "to_ready");
    run_read(0, 'h7777, lat);
    chk("to_latency", 32'(lat), TO + 1);
    chk("to_rsp_valid", 32'(rsp_valid), 2);
    chk("to_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("to_err", 32'(rsp_err), 1);
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 'h7777;
    @(negedge clk);
    chk("stray_rsp_valid", 32'(rsp_valid), 0);
    chk("stray_rdata", rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rsp_valid2", 32'(rsp_valid), 0);
    chk("stray_bus_rd", 32'(bus_rd), 0);

    // rvalid in the same cycle the timeout would fire: data wins, no error.
    grant(2'b01, 'h44, 2'b01, "co_ready");
    run_read(TO, 'h4242, lat);
    chk("co_latency", 32'(lat), TO + 1);
    chk("co_rsp_valid", 32'(rsp_valid), 1);
    chk("co_rdata", rsp_rdata, 'h4242);
    chk("co_err", 32'(rsp_err), 0);

    // Reset in WAIT_RD: pointer would favour requester 1, reset restarts at 0.
    grant(2'b01, 'h50, 2'b01, "wr_ready");
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("wr_issue_rd", 32'(bus_rd), 1);
    @(posedge clk); #1;
    resetn = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    chk("wr_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("wr_post_rsp_valid", 32'(rsp_valid), 0);
    chk("wr_post_strobes", 32'({bus_wr, bus_rd}), 0);
    chk("wr_post_addr", bus_addr, 0);
    chk("wr_post_rdata", rsp_rdata, 0);
    chk("wr_post_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("wr_next_addr", bus_addr, 'h50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
